// File: rtl/gcn_pkg.sv
// Shared widths, FSM state encoding and row type for the GCN COO aggregation stage.
package gcn_pkg;

    localparam int FEATURE_ROWS      = 6;
    localparam int WEIGHT_COLS       = 3;
    localparam int DOT_PROD_WIDTH    = 16;
    localparam int COO_NUM_OF_COLS   = 6;
    localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
    localparam int MAX_ADDRESS_WIDTH = 2;
    localparam int ROW_BW            = $clog2(FEATURE_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EDGE,
        ARGMAX,
        DONE
    } state_t;

    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_row_t;

endpackage

// File: rtl/gcn_argmax_row.sv
// Combinational argmax across one AGG row; on equal values the lowest column index wins.
module gcn_argmax_row
    import gcn_pkg::*;
(
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_row,
    output logic [MAX_ADDRESS_WIDTH-1:0]               max_idx
);

    logic [DOT_PROD_WIDTH-1:0] best;

    // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
    always_comb begin
        max_idx = '0;
        best    = agg_row[0];
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (agg_row[c] > best) begin
                best    = agg_row[c];
                max_idx = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/gcn_coo_aggregation.sv
// Forms AGG = (A + I) * FW by walking a COO edge list one edge per cycle, then argmaxes each row.
module gcn_coo_aggregation
    import gcn_pkg::*;
(
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      start,
    input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
    input  logic [2*COO_BW-1:0]                                       coo_in,
    output logic [COO_BW-1:0]                                         coo_address,
    output logic                                                      done,
    output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]            max_addi_answer
);

    localparam logic [COO_BW-1:0] MAX_ID    = COO_BW'(FEATURE_ROWS);
    localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);
    localparam logic [ROW_BW-1:0] LAST_ROW  = ROW_BW'(FEATURE_ROWS - 1);

    state_t                      state;
    agg_row_t [FEATURE_ROWS-1:0] agg;
    logic [COO_BW-1:0]           edge_cnt;
    logic [ROW_BW-1:0]           row_cnt;
    logic [MAX_ADDRESS_WIDTH-1:0] row_max;

    logic [COO_BW-1:0] src_id, dst_id, src_idx, dst_idx;
    logic              edge_ok;

    // edge_cnt returns to zero when the walk ends, so the address reads 0 in every other state.
    assign coo_address = edge_cnt;

    // COO node ids are 1-based; id 0 or an id past the last node marks an unused edge slot.
    always_comb begin
        src_id  = coo_in[2*COO_BW-1:COO_BW];
        dst_id  = coo_in[COO_BW-1:0];
        src_idx = src_id - COO_BW'(1);
        dst_idx = dst_id - COO_BW'(1);
        edge_ok = (src_id != '0) && (dst_id != '0) && (src_id <= MAX_ID) && (dst_id <= MAX_ID);
    end

    gcn_argmax_row u_argmax (
        .agg_row (agg[row_cnt]),
        .max_idx (row_max)
    );

    // NOTE: AGG is reset along with the FSM because an aborted run must leave no partial sums visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            agg             <= '0;
            edge_cnt        <= '0;
            row_cnt         <= '0;
            done            <= 1'b0;
            max_addi_answer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    agg      <= fm_wm_in;
                    edge_cnt <= '0;
                    state    <= EDGE;
                end
                EDGE: begin
                    // Neighbour terms always come from FW so edge order never matters.
                    if (edge_ok) begin
                        for (int c = 0; c < WEIGHT_COLS; c++) begin
                            agg[src_idx][c] <= agg[src_idx][c] + fm_wm_in[dst_idx][c];
                            if (src_idx != dst_idx)
                                agg[dst_idx][c] <= agg[dst_idx][c] + fm_wm_in[src_idx][c];
                        end
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        edge_cnt <= '0;
                        row_cnt  <= '0;
                        state    <= ARGMAX;
                    end else begin
                        edge_cnt <= edge_cnt + COO_BW'(1);
                    end
                end
                ARGMAX: begin
                    max_addi_answer[row_cnt] <= row_max;
                    if (row_cnt == LAST_ROW) begin
                        row_cnt <= '0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        row_cnt <= row_cnt + ROW_BW'(1);
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_coo_aggregation.sv
// Scoreboard bench for gcn_coo_aggregation: expected argmax vectors are queued at launch, popped at done.
module tb_gcn_coo_aggregation;
    import gcn_pkg::*;

    typedef logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fw_t;
    typedef logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]               ans_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    fw_t               fw;
    logic [2*COO_BW-1:0] coo_in;
    logic [COO_BW-1:0] coo_address;
    logic              done;
    ans_t              max_addi_answer;

    logic [2*COO_BW-1:0] coo_mem [COO_NUM_OF_COLS];
    ans_t                exp_q [$];
    int                  vectors = 0;
    int                  miscompares = 0;

    gcn_coo_aggregation dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fm_wm_in        (fw),
        .coo_in          (coo_in),
        .coo_address     (coo_address),
        .done            (done),
        .max_addi_answer (max_addi_answer)
    );

    always #5 clk = ~clk;

    always_comb begin
        coo_in = '0;
        if (int'(coo_address) < COO_NUM_OF_COLS) coo_in = coo_mem[coo_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*COO_BW-1:0] mk_edge(input int s, input int d);
        return {COO_BW'(s), COO_BW'(d)};
    endfunction

    task automatic clear_case();
        fw = '0;
        for (int e = 0; e < COO_NUM_OF_COLS; e++) coo_mem[e] = '0;
    endtask

    // Reference: self loop, then undirected neighbour sums (16-bit wrap), argmax with low-index ties.
    function automatic ans_t model();
        fw_t  agg;
        ans_t ans;
        int   s, d, best;
        agg = fw;
        for (int e = 0; e < COO_NUM_OF_COLS; e++) begin
            s = int'(coo_mem[e][2*COO_BW-1:COO_BW]);
            d = int'(coo_mem[e][COO_BW-1:0]);
            if (s >= 1 && s <= FEATURE_ROWS && d >= 1 && d <= FEATURE_ROWS) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    if (s == d) begin
                        agg[s-1][c] = agg[s-1][c] + fw[s-1][c];
                    end else begin
                        agg[s-1][c] = agg[s-1][c] + fw[d-1][c];
                        agg[d-1][c] = agg[d-1][c] + fw[s-1][c];
                    end
                end
            end
        end
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            best = 0;
            for (int c = 1; c < WEIGHT_COLS; c++)
                if (agg[r][c] > agg[r][best]) best = c;
            ans[r] = MAX_ADDRESS_WIDTH'(best);
        end
        return ans;
    endfunction

    task automatic run_case(input string tag, input bit hold);
        ans_t exp;
        int   n;
        bit   seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n <= COO_NUM_OF_COLS + 1)
                check({tag, "_addr"}, 32'(coo_address), (n <= COO_NUM_OF_COLS) ? 32'(n - 1) : 32'd0);
            seen = done;
        end
        check({tag, "_latency"}, 32'(n), 32'(1 + COO_NUM_OF_COLS + FEATURE_ROWS));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            for (int r = 0; r < FEATURE_ROWS; r++)
                check($sformatf("%s_ans%0d", tag, r), 32'(max_addi_answer[r]), 32'(exp[r]));
        end
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_done"}, 32'(done), 32'd1);
            end
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, 32'(done), 32'd0);
    endtask

    task automatic load_single_edge();
        clear_case();
        fw[0][0] = 16'd5;
        fw[1][1] = 16'd7;
        coo_mem[0] = mk_edge(1, 2);
    endtask

    initial begin
        clear_case();
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 32'd0);
        check("reset_addr", 32'(coo_address), 32'd0);
        check("reset_ans", 32'(max_addi_answer), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // No edges: AGG == FW, column 2 largest everywhere.
        clear_case();
        for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
                fw[r][c] = DOT_PROD_WIDTH'((r + 1) * (c + 1));
        exp_q.push_back({FEATURE_ROWS{2'd2}});
        run_case("no_edges", 1'b0);

        // Abort mid-EDGE: everything returns to reset values.
        load_single_edge();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(coo_address), 32'd0);
        check("abort_ans", 32'(max_addi_answer), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single edge (1,2) rerun after the abort: rows 0,1 -> 1, rest all-zero tie -> 0.
        exp_q.push_back({2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1});
        run_case("single_edge", 1'b0);

        // Self edge (3,3): AGG[2] = {8,8,2}, tie resolves to column 0.
        clear_case();
        fw[2] = {16'd1, 16'd4, 16'd4};
        coo_mem[2] = mk_edge(3, 3);
        exp_q.push_back('0);
        run_case("self_edge", 1'b0);

        // Self edge plus (2,3): double-adding the self term would flip row 2 to column 0.
        clear_case();
        fw[2] = {16'd1, 16'd4, 16'd4};
        fw[1] = {16'd7, 16'd0, 16'd0};
        coo_mem[0] = mk_edge(3, 3);
        coo_mem[4] = mk_edge(2, 3);
        exp_q.push_back({2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0});
        run_case("self_plus", 1'b0);

        // Wrap: column 0 sums to 0x10000 -> 0, so column 1 (5) wins in rows 0 and 1.
        clear_case();
        fw[0] = {16'd0, 16'd5, 16'hFFFF};
        fw[1] = {16'd0, 16'd0, 16'd1};
        coo_mem[3] = mk_edge(1, 2);
        coo_mem[1] = mk_edge(7, 1);
        coo_mem[5] = mk_edge(0, 2);
        exp_q.push_back({2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1});
        run_case("wrap", 1'b0);

        // Full ring with start held high through DONE.
        clear_case();
        for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
                fw[r][c] = DOT_PROD_WIDTH'((r * 7 + c * 11 + 3) % 17);
        for (int e = 0; e < COO_NUM_OF_COLS; e++)
            coo_mem[e] = mk_edge(e + 1, (e + 1) % FEATURE_ROWS + 1);
        exp_q.push_back(model());
        run_case("ring", 1'b1);

        // Random edge lists including invalid ids and wide values.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < FEATURE_ROWS; r++)
                for (int c = 0; c < WEIGHT_COLS; c++)
                    fw[r][c] = DOT_PROD_WIDTH'($urandom);
            for (int e = 0; e < COO_NUM_OF_COLS; e++)
                coo_mem[e] = mk_edge($urandom_range(0, 7), $urandom_range(0, 7));
            exp_q.push_back(model());
            run_case($sformatf("rand%0d", k), 1'b0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
